// File: rtl/maze_tile_renderer_if.sv
// Pixel-stream and pellet-eat signals between the VGA timing side, the
// movement logic and the maze tile renderer.
interface maze_tile_renderer_if;
  logic [9:0]  p_row;
  logic [9:0]  p_col;
  logic [11:0] color_data;
  logic        fill;
  logic        eat_req;
  logic [5:0]  eat_row;
  logic [5:0]  eat_col;
  logic        eat_ack;
  logic        eat_hit;

  modport master (
    output p_row, p_col, eat_req, eat_row, eat_col,
    input  color_data, fill, eat_ack, eat_hit
  );

  modport slave (
    input  p_row, p_col, eat_req, eat_row, eat_col,
    output color_data, fill, eat_ack, eat_hit
  );
endinterface

// File: rtl/maze_tile_renderer.sv
// Writable ROWS x COLS maze tile map with a 2-cycle pixel render pipeline and
// pellet-eat tracking. Define POWER_PELLET_EN to load and draw power pellets.
module maze_tile_renderer #(
  parameter int          ROWS         = 8,
  parameter int          COLS         = 8,
  parameter int          TILE_PX      = 32,
  parameter int          ORIGIN_X     = 192,
  parameter int          ORIGIN_Y     = 112,
  parameter logic [11:0] WALL_COLOR   = 12'h00F,
  parameter logic [11:0] PATH_COLOR   = 12'h000,
  parameter logic [11:0] PELLET_COLOR = 12'hFFF,
  parameter logic [11:0] POWER_COLOR  = 12'hFF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_start,
  maze_tile_renderer_if.slave  bus,
  output logic [11:0]          pellet_count,
  output logic                 level_clear,
  output logic                 busy
);

  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int TSH    = $clog2(TILE_PX);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] T_WALL   = 2'd0;
  localparam logic [1:0] T_PATH   = 2'd1;
  localparam logic [1:0] T_PELLET = 2'd2;

  localparam logic [15:0] X_LO = 16'(ORIGIN_X);
  localparam logic [15:0] X_HI = 16'(ORIGIN_X + COLS * TILE_PX);
  localparam logic [15:0] Y_LO = 16'(ORIGIN_Y);
  localparam logic [15:0] Y_HI = 16'(ORIGIN_Y + ROWS * TILE_PX);

  localparam logic [TSH-1:0] PEL_LO = TSH'(3 * TILE_PX / 8);
  localparam logic [TSH-1:0] PEL_HI = TSH'(5 * TILE_PX / 8);
`ifdef POWER_PELLET_EN
  localparam logic [1:0]     T_POWER = 2'd3;
  localparam logic [TSH-1:0] PWR_LO  = TSH'(TILE_PX / 4);
  localparam logic [TSH-1:0] PWR_HI  = TSH'(3 * TILE_PX / 4);
`endif

  localparam logic [6:0] ROWS7    = 7'(ROWS);
  localparam logic [6:0] COLS7    = 7'(COLS);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] r, input logic [5:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  function automatic logic [1:0] default_code(input logic [5:0] r, input logic [5:0] c);
    int ri;
    int ci;
    ri = int'(r);
    ci = int'(c);
    if (ri == 0 || ri == ROWS - 1 || ci == 0 || ci == COLS - 1) return T_WALL;
`ifdef POWER_PELLET_EN
    if ((ri == 1 || ri == ROWS - 2) && (ci == 1 || ci == COLS - 2)) return T_POWER;
`endif
    return T_PELLET;
  endfunction

  function automatic logic in_win(input logic [TSH-1:0] off, input logic [TSH-1:0] lo,
                                  input logic [TSH-1:0] hi);
    return (off >= lo) && (off < hi);
  endfunction

  logic [1:0] mem [CELLS];

  logic [0:0]        state_reg, state_next;
  logic [5:0]        init_row_reg, init_row_next;
  logic [5:0]        init_col_reg, init_col_next;
  logic [11:0]       count_reg, count_next;
  logic              level_reg, level_next;
  logic              eat_ack_reg, eat_hit_reg;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;

  // Eat/init port: combinational read so the rewrite lands at the same edge
  // that registers the ack; a following request then sees the new code.
  logic              eat_in_range, eat_hit_now;
  logic [ADDR_W-1:0] eat_addr;
  logic [1:0]        eat_code, init_code;

  assign eat_in_range = ({1'b0, bus.eat_row} < ROWS7) && ({1'b0, bus.eat_col} < COLS7);
  assign eat_addr     = eat_in_range ? tile_addr(bus.eat_row, bus.eat_col) : '0;
  assign eat_code     = mem[eat_addr];
  assign eat_hit_now  = (state_reg == ST_RUN) && !init_start && bus.eat_req &&
                        eat_in_range && eat_code[1];
  assign init_code    = default_code(init_row_reg, init_col_reg);

  always_comb begin
    state_next    = state_reg;
    init_row_next = init_row_reg;
    init_col_next = init_col_reg;
    count_next    = count_reg;
    wr_en         = 1'b0;
    wr_addr       = tile_addr(init_row_reg, init_col_reg);
    wr_data       = init_code;
    if (init_start) begin
      state_next    = ST_INIT;
      init_row_next = '0;
      init_col_next = '0;
      count_next    = '0;
    end else if (state_reg == ST_INIT) begin
      wr_en = 1'b1;
      if (init_code[1]) count_next = count_reg + 12'd1;
      if (init_col_reg == LAST_COL) begin
        init_col_next = '0;
        if (init_row_reg == LAST_ROW) begin
          init_row_next = '0;
          state_next    = ST_RUN;
        end else begin
          init_row_next = init_row_reg + 6'd1;
        end
      end else begin
        init_col_next = init_col_reg + 6'd1;
      end
    end else if (eat_hit_now) begin
      wr_en   = 1'b1;
      wr_addr = eat_addr;
      wr_data = T_PATH;
      if (count_reg != 12'd0) count_next = count_reg - 12'd1;
    end
    level_next = (state_next == ST_RUN) && (count_next == 12'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      init_row_reg <= '0;
      init_col_reg <= '0;
      count_reg    <= '0;
      level_reg    <= 1'b0;
      eat_ack_reg  <= 1'b0;
      eat_hit_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      init_row_reg <= init_row_next;
      init_col_reg <= init_col_next;
      count_reg    <= count_next;
      level_reg    <= level_next;
      eat_ack_reg  <= bus.eat_req;
      eat_hit_reg  <= eat_hit_now;
    end
  end

  // Render stage 1: region test, tile address and in-tile offsets.
  logic [15:0]       px_row, px_col, dy, dx;
  logic              in_region;
  logic [ADDR_W-1:0] pix_addr;
  logic              in_reg;
  logic [TSH-1:0]    orow_reg, ocol_reg;
  logic [1:0]        tile_q;

  assign px_row    = {6'd0, bus.p_row};
  assign px_col    = {6'd0, bus.p_col};
  assign dy        = px_row - Y_LO;
  assign dx        = px_col - X_LO;
  assign in_region = (px_row >= Y_LO) && (px_row < Y_HI) && (px_col >= X_LO) && (px_col < X_HI);
  assign pix_addr  = in_region ? tile_addr(6'(dy >> TSH), 6'(dx >> TSH)) : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    tile_q <= mem[pix_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_reg   <= 1'b0;
      orow_reg <= '0;
      ocol_reg <= '0;
    end else begin
      in_reg   <= in_region;
      orow_reg <= dy[TSH-1:0];
      ocol_reg <= dx[TSH-1:0];
    end
  end

  // Render stage 2: tile code to colour.
  logic [11:0] tile_color;
  logic [11:0] color_reg;
  logic        fill_reg;

  always_comb begin
    tile_color = PATH_COLOR;
    case (tile_q)
      T_WALL:   tile_color = WALL_COLOR;
      T_PELLET: if (in_win(orow_reg, PEL_LO, PEL_HI) && in_win(ocol_reg, PEL_LO, PEL_HI))
                  tile_color = PELLET_COLOR;
`ifdef POWER_PELLET_EN
      T_POWER:  if (in_win(orow_reg, PWR_LO, PWR_HI) && in_win(ocol_reg, PWR_LO, PWR_HI))
                  tile_color = POWER_COLOR;
`endif
      default:  tile_color = PATH_COLOR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_reg <= '0;
      fill_reg  <= 1'b0;
    end else if (state_reg == ST_RUN && in_reg) begin
      color_reg <= tile_color;
      fill_reg  <= 1'b1;
    end else begin
      color_reg <= '0;
      fill_reg  <= 1'b0;
    end
  end

  assign bus.color_data = color_reg;
  assign bus.fill       = fill_reg;
  assign bus.eat_ack    = eat_ack_reg;
  assign bus.eat_hit    = eat_hit_reg;
  assign pellet_count   = count_reg;
  assign level_clear    = level_reg;
  assign busy           = (state_reg == ST_INIT);

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Self-checking bench for maze_tile_renderer against a tile-array reference model.
module tb_maze_tile_renderer;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int T    = 32;
  localparam int OX   = 192;
  localparam int OY   = 112;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_start;
  logic [11:0] pellet_count;
  logic        level_clear;
  logic        busy;

  maze_tile_renderer_if bus();

  maze_tile_renderer #(
    .ROWS(ROWS), .COLS(COLS), .TILE_PX(T), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .WALL_COLOR(12'h00F), .PATH_COLOR(12'h000), .PELLET_COLOR(12'hFFF), .POWER_COLOR(12'hFF0)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .bus(bus),
    .pellet_count(pellet_count), .level_clear(level_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model [ROWS][COLS];
  int model_count;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_init();
    model_count = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) model[r][c] = 0;
        else model[r][c] = 2;
`ifdef POWER_PELLET_EN
        if ((r == 1 || r == ROWS - 2) && (c == 1 || c == COLS - 2)) model[r][c] = 3;
`endif
        if (model[r][c] >= 2) model_count++;
      end
  endfunction

  function automatic logic model_eat(input int r, input int c);
    if (r >= ROWS || c >= COLS) return 1'b0;
    if (model[r][c] < 2) return 1'b0;
    model[r][c] = 1;
    if (model_count > 0) model_count--;
    return 1'b1;
  endfunction

  function automatic void ref_pixel(input int row, input int col,
                                    output logic [11:0] color, output logic fill);
    int tr, tc, orw, ocl;
    color = 12'h000;
    fill  = 1'b0;
    if (row < OY || row >= OY + ROWS * T || col < OX || col >= OX + COLS * T) return;
    fill = 1'b1;
    tr = (row - OY) / T;  orw = (row - OY) % T;
    tc = (col - OX) / T;  ocl = (col - OX) % T;
    case (model[tr][tc])
      0: color = 12'h00F;
      2: if (orw * 8 >= 3 * T && orw * 8 < 5 * T && ocl * 8 >= 3 * T && ocl * 8 < 5 * T)
           color = 12'hFFF;
      3: if (orw * 4 >= T && orw * 4 < 3 * T && ocl * 4 >= T && ocl * 4 < 3 * T)
           color = 12'hFF0;
      default: color = 12'h000;
    endcase
  endfunction

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic probe(input int row, input int col, output logic [11:0] color, output logic fill);
    bus.p_row = 10'(row);
    bus.p_col = 10'(col);
    step();
    step();
    color = bus.color_data;
    fill  = bus.fill;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; init_start = 1'b0;
    bus.p_row = '0; bus.p_col = '0; bus.eat_req = 1'b0; bus.eat_row = '0; bus.eat_col = '0;
    step(); step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
    tests++; if (pellet_count !== 12'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", pellet_count); end
    tests++; if (bus.fill !== 1'b0 || bus.color_data !== 12'h000) begin fails++; $display("FAIL reset_pixel: got fill=%b color=%h want 0/000", bus.fill, bus.color_data); end
    tests++; if (bus.eat_ack !== 1'b0 || bus.eat_hit !== 1'b0 || level_clear !== 1'b0) begin fails++; $display("FAIL reset_flags: got ack=%b hit=%b lvl=%b want 0", bus.eat_ack, bus.eat_hit, level_clear); end
    reset = 1'b0;
    model_init();
    count_busy(n);
    tests++; if (n != ROWS * COLS) begin fails++; $display("FAIL init_len: got %0d want %0d", n, ROWS * COLS); end
    tests++; if (pellet_count !== 12'(model_count) || model_count != 36) begin fails++; $display("FAIL init_count: got %0d want 36", pellet_count); end
    tests++; if (level_clear !== 1'b0) begin fails++; $display("FAIL init_level: got %b want 0", level_clear); end
    $display("[TB] reset/init: busy for %0d cycles, pellet_count=%0d", n, pellet_count);
  endtask

  task automatic test_render_directed();
    logic [11:0] col;
    logic        f;
    logic [11:0] centre_exp;
`ifdef POWER_PELLET_EN
    centre_exp = 12'hFF0;
`else
    centre_exp = 12'h000;
`endif
    probe(160, 240, col, f);
    tests++; if (f !== 1'b1 || col !== 12'hFFF) begin fails++; $display("FAIL pix_pellet: got fill=%b color=%h want 1/FFF", f, col); end
    probe(152, 232, col, f);
    tests++; if (f !== 1'b1 || col !== centre_exp) begin fails++; $display("FAIL pix_offset8: got fill=%b color=%h want 1/%h", f, col, centre_exp); end
    probe(120, 200, col, f);
    tests++; if (f !== 1'b1 || col !== 12'h00F) begin fails++; $display("FAIL pix_wall: got fill=%b color=%h want 1/00F", f, col); end
    probe(100, 240, col, f);
    tests++; if (f !== 1'b0 || col !== 12'h000) begin fails++; $display("FAIL pix_outside: got fill=%b color=%h want 0/000", f, col); end
    probe(OY + ROWS * T, OX, col, f);
    tests++; if (f !== 1'b0 || col !== 12'h000) begin fails++; $display("FAIL pix_bottom_edge: got fill=%b color=%h want 0/000", f, col); end
    probe(OY + ROWS * T - 1, OX + COLS * T - 1, col, f);
    tests++; if (f !== 1'b1 || col !== 12'h00F) begin fails++; $display("FAIL pix_last_inside: got fill=%b color=%h want 1/00F", f, col); end
    $display("[TB] directed pixels done");
  endtask

  task automatic test_render_random();
    logic [11:0] exp_c [$];
    logic        exp_f [$];
    logic [11:0] ec;
    logic        ef;
    int row, col;
    for (int i = 0; i < 60; i++) begin
      if (($urandom & 3) == 0) begin
        row = int'($urandom_range(0, 1023)); col = int'($urandom_range(0, 1023));
      end else begin
        row = int'($urandom_range(OY - 8, OY + ROWS * T + 8));
        col = int'($urandom_range(OX - 8, OX + COLS * T + 8));
      end
      ref_pixel(row, col, ec, ef);
      exp_c.push_back(ec); exp_f.push_back(ef);
      bus.p_row = 10'(row); bus.p_col = 10'(col);
      step();
      if (exp_c.size() >= 2) begin
        ec = exp_c.pop_front(); ef = exp_f.pop_front();
        tests++; if (bus.color_data !== ec || bus.fill !== ef) begin fails++; $display("FAIL pix_random: got fill=%b color=%h want %b/%h", bus.fill, bus.color_data, ef, ec); end
      end
    end
    step();
    ec = exp_c.pop_front(); ef = exp_f.pop_front();
    tests++; if (bus.color_data !== ec || bus.fill !== ef) begin fails++; $display("FAIL pix_random_last: got fill=%b color=%h want %b/%h", bus.fill, bus.color_data, ef, ec); end
    $display("[TB] random pixel stream done");
  endtask

  task automatic test_back_to_back();
    logic [11:0] col;
    logic        f;
    logic        dummy;
    bus.eat_req = 1'b1; bus.eat_row = 6'd1; bus.eat_col = 6'd1;
    dummy = model_eat(1, 1);
    step();
    tests++; if (bus.eat_ack !== 1'b1 || bus.eat_hit !== 1'b1 || pellet_count !== 12'd35) begin fails++; $display("FAIL eat_first: got ack=%b hit=%b count=%0d want 1/1/35", bus.eat_ack, bus.eat_hit, pellet_count); end
    dummy = model_eat(1, 1);
    step();
    tests++; if (bus.eat_ack !== 1'b1 || bus.eat_hit !== 1'b0 || pellet_count !== 12'd35) begin fails++; $display("FAIL eat_second: got ack=%b hit=%b count=%0d want 1/0/35", bus.eat_ack, bus.eat_hit, pellet_count); end
    bus.eat_req = 1'b0;
    step();
    tests++; if (bus.eat_ack !== 1'b0) begin fails++; $display("FAIL eat_ack_pulse: got %b want 0", bus.eat_ack); end
    probe(160, 240, col, f);
    tests++; if (f !== 1'b1 || col !== 12'h000) begin fails++; $display("FAIL pix_eaten: got fill=%b color=%h want 1/000", f, col); end
    $display("[TB] back-to-back eat at (1,1) done, pellet_count=%0d", pellet_count);
  endtask

  task automatic test_eat_miss();
    int rows [3] = '{0, 8, 3};
    int cols [3] = '{3, 3, 63};
    for (int i = 0; i < 3; i++) begin
      bus.eat_req = 1'b1; bus.eat_row = 6'(rows[i]); bus.eat_col = 6'(cols[i]);
      step();
      tests++; if (bus.eat_ack !== 1'b1 || bus.eat_hit !== 1'b0 || pellet_count !== 12'(model_count)) begin fails++; $display("FAIL eat_miss(%0d,%0d): got ack=%b hit=%b count=%0d want 1/0/%0d", rows[i], cols[i], bus.eat_ack, bus.eat_hit, pellet_count, model_count); end
    end
    bus.eat_req = 1'b0;
    step();
    $display("[TB] wall / out-of-range eats done");
  endtask

  task automatic test_eat_all();
    int r, c;
    logic eh;
    for (int i = 0; i < 30 + ROWS * COLS; i++) begin
      if (i < 30) begin
        r = int'($urandom_range(0, 9)); c = int'($urandom_range(0, 9));
      end else begin
        r = (i - 30) / COLS; c = (i - 30) % COLS;
      end
      bus.eat_req = 1'b1; bus.eat_row = 6'(r); bus.eat_col = 6'(c);
      eh = model_eat(r, c);
      step();
      tests++; if (bus.eat_ack !== 1'b1 || bus.eat_hit !== eh || pellet_count !== 12'(model_count) || level_clear !== (model_count == 0)) begin fails++; $display("FAIL eat_stream(%0d,%0d): got ack=%b hit=%b count=%0d lvl=%b want 1/%b/%0d/%b", r, c, bus.eat_ack, bus.eat_hit, pellet_count, level_clear, eh, model_count, model_count == 0); end
    end
    bus.eat_req = 1'b0;
    step();
    tests++; if (pellet_count !== 12'd0 || level_clear !== 1'b1) begin fails++; $display("FAIL eat_all: got count=%0d lvl=%b want 0/1", pellet_count, level_clear); end
    $display("[TB] all pellets eaten, level_clear=%b", level_clear);
  endtask

  task automatic test_init_restart();
    int n;
    logic [11:0] col;
    logic        f;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    tests++; if (busy !== 1'b1 || pellet_count !== 12'd0 || level_clear !== 1'b0) begin fails++; $display("FAIL restart_entry: got busy=%b count=%0d lvl=%b want 1/0/0", busy, pellet_count, level_clear); end
    bus.eat_req = 1'b1; bus.eat_row = 6'd2; bus.eat_col = 6'd2;
    step();
    bus.eat_req = 1'b0;
    tests++; if (bus.eat_ack !== 1'b1 || bus.eat_hit !== 1'b0) begin fails++; $display("FAIL eat_in_init: got ack=%b hit=%b want 1/0", bus.eat_ack, bus.eat_hit); end
    probe(160, 240, col, f);
    tests++; if (f !== 1'b0 || col !== 12'h000) begin fails++; $display("FAIL pix_in_init: got fill=%b color=%h want 0/000", f, col); end
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    model_init();
    count_busy(n);
    tests++; if (n != ROWS * COLS) begin fails++; $display("FAIL restart_len: got %0d want %0d", n, ROWS * COLS); end
    tests++; if (pellet_count !== 12'd36 || level_clear !== 1'b0) begin fails++; $display("FAIL restart_count: got count=%0d lvl=%b want 36/0", pellet_count, level_clear); end
    probe(160, 240, col, f);
    tests++; if (f !== 1'b1 || col !== 12'hFFF) begin fails++; $display("FAIL pix_reloaded: got fill=%b color=%h want 1/FFF", f, col); end
    $display("[TB] init_start reload: busy for %0d cycles, pellet_count=%0d", n, pellet_count);
  endtask

  task automatic test_reset_mid_init();
    int n;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    #2;
    tests++; if (busy !== 1'b1 || pellet_count !== 12'd0 || level_clear !== 1'b0) begin fails++; $display("FAIL async_reset: got busy=%b count=%0d lvl=%b want 1/0/0", busy, pellet_count, level_clear); end
    step();
    reset = 1'b0;
    count_busy(n);
    tests++; if (n != ROWS * COLS || pellet_count !== 12'd36) begin fails++; $display("FAIL reinit_after_reset: got len=%0d count=%0d want %0d/36", n, pellet_count, ROWS * COLS); end
    $display("[TB] reset mid-INIT: busy for %0d cycles, pellet_count=%0d", n, pellet_count);
  endtask

  initial begin
    test_reset();
    test_render_directed();
    test_render_random();
    test_back_to_back();
    test_eat_miss();
    test_eat_all();
    test_init_restart();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maze_tile_renderer.md
Name: maze_tile_renderer

Overview:
Parametrised, writable successor to the fixed 8x8 maze view.
- Holds a ROWS x COLS tile map in block RAM, 2 bits per tile.
- Renders the map, including pellets, onto the VGA pixel stream with a fixed pipeline latency.
- Accepts pellet-eat requests from the pacman movement logic and tracks the pellets remaining.
- Sits between the VGA timing generator and the pixel mux.

Parameters:
- ROWS, 8, tile rows (3..64)
- COLS, 8, tile columns (3..64)
- TILE_PX, 32, tile edge in pixels; power of two, >= 8
- ORIGIN_X, 192, left pixel column of the maze
- ORIGIN_Y, 112, top pixel row of the maze
- WALL_COLOR, 12'h00F, wall RGB444
- PATH_COLOR, 12'h000, empty path RGB444
- PELLET_COLOR, 12'hFFF, pellet RGB444
- POWER_COLOR, 12'hFF0, power pellet RGB444

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- init_start  in  1  single-cycle pulse; reloads the default maze
- p_row  in  10  current pixel row, top-left is 0,0
- p_col  in  10  current pixel column
- color_data  out  12  RGB444 pixel, valid 2 cycles after p_row/p_col
- fill  out  1  pixel lies inside the maze, aligned with color_data
- eat_req  in  1  request to eat the tile at eat_row/eat_col
- eat_row  in  6  tile row of the request
- eat_col  in  6  tile column of the request
- eat_ack  out  1  one-cycle pulse, 1 cycle after eat_req
- eat_hit  out  1  valid with eat_ack; the tile held a pellet or power pellet
- pellet_count  out  12  pellets remaining
- level_clear  out  1  high while in RUN with pellet_count==0
- busy  out  1  high during INIT

Behaviour:
- Tile codes: 0 wall, 1 empty path, 2 pellet, 3 power pellet.
- Default layout:
  - Border tiles (r==0, r==ROWS-1, c==0, c==COLS-1) are wall.
  - All other tiles are pellet.
- Reset, asynchronous:
  - FSM goes to INIT; init address = 0; pellet_count = 0.
  - color_data = 0, fill = 0, eat_ack = 0, eat_hit = 0, level_clear = 0, busy = 1.
- FSM INIT:
  - Writes one tile per cycle at address r*COLS+c, ascending, using the default layout.
  - pellet_count increments for each code 2 or 3 tile written.
  - After address ROWS*COLS-1 is written, moves to RUN. INIT lasts ROWS*COLS cycles.
- FSM RUN:
  - init_start clears pellet_count and returns the FSM to INIT at address 0.
  - init_start during INIT restarts the sequence at address 0.
- Render pipeline, 2-cycle latency:
  - Stage 1 registers in-region, tile_row=(p_row-ORIGIN_Y)/TILE_PX, tile_col, and the in-tile offsets. Division and modulo are shifts.
  - In-region means ORIGIN_Y <= p_row < ORIGIN_Y+ROWS*TILE_PX, and likewise for columns.
  - Stage 2 reads the RAM and registers color_data and fill.
  - Outside the region: fill=0, color_data=0.
  - During INIT: fill=0, color_data=0.
  - Wall: WALL_COLOR.
  - Pellet: PELLET_COLOR when both offsets lie in [3T/8, 5T/8), where T=TILE_PX; otherwise PATH_COLOR.
  - Power pellet: POWER_COLOR when both offsets lie in [T/4, 3T/4); otherwise PATH_COLOR.
  - Empty path: PATH_COLOR.
- Eat handshake, RUN only:
  - eat_req is sampled each cycle; requests are back-to-back capable.
  - The tile is read and, if its code is 2 or 3, rewritten to 1 and pellet_count decrements.
  - eat_ack pulses on the next cycle, with eat_hit=1 in that case.
  - Wall, empty-path, or out-of-range coordinates (eat_row>=ROWS or eat_col>=COLS) produce eat_ack with eat_hit=0 and no write.
  - Consecutive requests to the same tile: the second returns eat_hit=0. The rewrite is forwarded, not read stale.
  - During INIT, eat_req produces eat_ack=1, eat_hit=0, no write.
- Memory ports: render port is read-only; eat/init port is read-write. A render read of a tile written in the same cycle returns old data.
- pellet_count never underflows. level_clear is registered.
- Reset mid-INIT or mid-eat aborts immediately; no partial state is retained.

Optional Feature:
- Macro POWER_PELLET_EN.
- Defined: tiles (1,1), (1,COLS-2), (ROWS-2,1), (ROWS-2,COLS-2) load as code 3 during INIT and count toward pellet_count.
- Not defined: code 3 is never written, and the power-pellet render path is not built.

Test Plan:
- Reset then release, defaults -> busy=1 for 64 cycles, then busy=0, pellet_count=36, level_clear=0.
- Pixel (row 160, col 240), which is tile (1,1) at offset (16,16) -> 2 cycles later fill=1, color_data=12'hFFF.
- Pixel (row 152, col 232), offset (8,8) -> color_data=12'h000, fill=1.
- Pixel (row 120, col 200), wall -> color_data=12'h00F.
- Pixel (row 100, col 240) -> fill=0, color_data=0.
- eat_req at (1,1) twice back-to-back -> first eat_ack with eat_hit=1 and pellet_count=35; second with eat_hit=0 and count still 35. Then pixel (160,240) -> 12'h000.
- eat_req at wall (0,3) -> eat_hit=0, count unchanged.
- Eat all 36 pellets -> pellet_count=0, level_clear=1.
- Then init_start -> busy=1 for 64 cycles, count=36, level_clear=0.
- With POWER_PELLET_EN defined: pixel (row 152, col 232) -> 12'hFF0; pellet_count=36 after INIT.
